// File: rtl/tdm_audio_pkg.sv
// Shared constants, engine state type and sizing helpers for the TDM/I2S audio transmitter.
package tdm_audio_pkg;

  localparam int unsigned FSYNC_I2S = 0;
  localparam int unsigned FSYNC_TDM = 1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } eng_state_e;

  function automatic int unsigned frame_bits(input int unsigned num_ch,
                                             input int unsigned slot_w);
    return num_ch * slot_w;
  endfunction

  // Level counter needs one extra bit to represent a completely full FIFO.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Frame FIFO with wrap-bit pointers; reports full/empty/level and flags writes dropped while full.
module audio_frame_fifo
  import tdm_audio_pkg::*;
#(
  parameter int unsigned Width = 48,
  parameter int unsigned Depth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [Width-1:0]          wdata_i,
  input  logic                      write_i,
  input  logic                      pop_i,
  output logic [Width-1:0]          rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [lvl_w(Depth)-1:0]   level_o,
  output logic                      overflow_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]     wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]     rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [Width-1:0]   mem_q [Depth];
  logic               wr_en, rd_en;

  // A write is judged against the registered full flag, so a same-cycle pop cannot rescue it.
  assign wr_en = write_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = write_i && full_o;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

  assign rdata_o    = mem_q[rd_ptr_q[AddrW-1:0]];
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/tdm_audio_tx.sv
// N-channel I2S/TDM serial audio transmitter with frame FIFO and BCLK derived from clk_i.
// Define TDM_AUDIO_TX_HOLD_LAST_EN to repeat the last sent frame on underrun instead of silence.
module tdm_audio_tx
  import tdm_audio_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FSYNC_MODE = 0
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             enable_i,
  input  logic [NUM_CH*SAMPLE_W-1:0]       frame_i,
  input  logic                             write_i,
  output logic                             full_o,
  output logic [lvl_w(FIFO_DEPTH)-1:0]     level_o,
  output logic                             overflow_o,
  output logic                             underrun_o,
  output logic                             bclk_o,
  output logic                             fsync_o,
  output logic                             sdata_o
);

  localparam int unsigned FrameW    = NUM_CH * SAMPLE_W;
  localparam int unsigned FrameBits = frame_bits(NUM_CH, SLOT_W);
  localparam int unsigned HalfDiv   = BCLK_DIV / 2;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned DivW      = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;

  eng_state_e            state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [BitW-1:0]       b_q, b_d, b_next;
  logic [FrameBits-1:0]  shift_q, shift_d;
  logic                  sdata_q, sdata_d;
  logic                  fsync_q, fsync_d;
  logic                  stop_q, stop_d;
  logic                  underrun_q, underrun_d;
  logic                  half_tick, fall_evt, boundary, pop;
  logic [FrameW-1:0]     fifo_rdata, underrun_frame;
  logic                  fifo_empty;

  audio_frame_fifo #(
    .Width (FrameW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rstn_i),
    .wdata_i    (frame_i),
    .write_i    (write_i),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .full_o     (full_o),
    .empty_o    (fifo_empty),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  // Slot-expanded stream, D[0] at the MSB: each sample MSB-first, left-justified, zero padded.
  function automatic logic [FrameBits-1:0] expand(input logic [FrameW-1:0] f);
    logic [FrameBits-1:0] s;
    s = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned k = 0; k < SAMPLE_W; k++) begin
        s[FrameBits-1-c*SLOT_W-k] = f[c*SAMPLE_W+SAMPLE_W-1-k];
      end
    end
    return s;
  endfunction

  function automatic logic fsync_for(input logic [BitW-1:0] b);
    if (FSYNC_MODE == FSYNC_TDM) return (b == '0);
    return (b >= BitW'(FrameBits / 2));
  endfunction

`ifdef TDM_AUDIO_TX_HOLD_LAST_EN
  logic [FrameW-1:0] last_q, last_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_q <= '0;
    else         last_q <= last_d;
  end

  assign underrun_frame = last_q;
`else
  assign underrun_frame = '0;
`endif

  assign half_tick = (state_q == StRun) && (div_q == DivW'(HalfDiv - 1));
  assign fall_evt  = half_tick && bclk_q;
  // b_q is preset to the last bit on entry, so the first falling event is a frame boundary.
  assign boundary  = fall_evt && !stop_q && (b_q == BitW'(FrameBits - 1));
  assign b_next    = (b_q == BitW'(FrameBits - 1)) ? '0 : b_q + 1'b1;
  assign pop       = boundary && enable_i && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bclk_d     = bclk_q;
    b_d        = b_q;
    shift_d    = shift_q;
    sdata_d    = sdata_q;
    fsync_d    = fsync_q;
    stop_d     = stop_q;
    underrun_d = 1'b0;
`ifdef TDM_AUDIO_TX_HOLD_LAST_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StRun;
          bclk_d  = 1'b1;
          div_d   = '0;
          b_d     = BitW'(FrameBits - 1);
          stop_d  = 1'b0;
        end
      end
      StRun: begin
        if (half_tick) begin
          div_d  = '0;
          bclk_d = !bclk_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (fall_evt) begin
          if (stop_q) begin
            // End of the trailing BCLK after the final delayed bit.
            state_d = StIdle;
            bclk_d  = 1'b0;
            sdata_d = 1'b0;
            fsync_d = 1'b0;
            b_d     = '0;
            shift_d = '0;
            stop_d  = 1'b0;
          end else begin
            sdata_d = shift_q[FrameBits-1];
            shift_d = {shift_q[FrameBits-2:0], 1'b0};
            b_d     = b_next;
            fsync_d = fsync_for(b_next);
            if (boundary) begin
              if (!enable_i) begin
                stop_d  = 1'b1;
                shift_d = '0;
              end else if (!fifo_empty) begin
                shift_d = expand(fifo_rdata);
`ifdef TDM_AUDIO_TX_HOLD_LAST_EN
                last_d  = fifo_rdata;
`endif
              end else begin
                shift_d    = expand(underrun_frame);
                underrun_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bclk_q     <= 1'b0;
      b_q        <= '0;
      shift_q    <= '0;
      sdata_q    <= 1'b0;
      fsync_q    <= 1'b0;
      stop_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      b_q        <= b_d;
      shift_q    <= shift_d;
      sdata_q    <= sdata_d;
      fsync_q    <= fsync_d;
      stop_q     <= stop_d;
      underrun_q <= underrun_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign fsync_o    = fsync_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;

endmodule
